// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter
// Store-and-forward receive filter between the MAC receive stream and the
// DMA receive stream. Each frame is written whole into a circular buffer
// and becomes readable only once its last beat is committed. Frames that
// fail the address filter, carry a bad-frame flag, or do not fit are
// discarded and counted.
//
// Ports:
//   clock, async_resetn        : clock and asynchronous active-low reset
//   mac_addr, promiscuous      : address filter settings (sampled on first beat)
//   s_axis_*                   : MAC receive stream (never backpressured)
//   m_axis_*                   : committed frame stream towards the DMA
//   frames_ok                  : frames committed (wraps)
//   drop_filter/error/overflow : saturating drop counters
module eth_rx_frame_filter #(
  parameter int depth_log2 = 9
) (
  input  logic        clock,
  input  logic        async_resetn,
  input  logic [47:0] mac_addr,
  input  logic        promiscuous,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] frames_ok,
  output logic [15:0] drop_filter,
  output logic [15:0] drop_error,
  output logic [15:0] drop_overflow
);

  localparam int AW = depth_log2;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]  rst_sync_r;
  logic        rst_n;
  wr_state_t   state_r, state_nxt_s;
  logic [AW:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [AW:0] commit_ptr_r, commit_nxt_s;
  logic [AW:0] rd_ptr_r;
  logic        we_s, inc_ok_s, inc_filt_s, inc_err_s, inc_ovf_s;
  logic [47:0] dst_s;
  logic        addr_ok_s, full_s;
  logic [72:0] mem [0:(1 << AW) - 1];
  logic [72:0] rd_word_r;
  logic        pend_r, pop_s, issue_s;
  logic [2:0]  occ_s;
  logic [72:0] q0_r, q1_r, q0_nxt_s, q1_nxt_s;
  logic        v0_r, v1_r, v0_nxt_s, v1_nxt_s;

  // Reset synchronizer: asserts immediately, releases two edges later
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) rst_sync_r <= 2'b00;
    else               rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign rst_n         = rst_sync_r[1];
  assign s_axis_tready = rst_n;

  // Byte 0 on the wire (tdata[7:0]) is the most significant address byte
  assign dst_s = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                  s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
  assign addr_ok_s = promiscuous || (dst_s == 48'hFFFF_FFFF_FFFF) || (dst_s == mac_addr);
  assign full_s    = ((wr_ptr_r - rd_ptr_r) == PTR_FULL);

  // Writer next-state: filter, overflow, error and commit decisions
  always_comb begin
    state_nxt_s  = state_r;
    wr_ptr_nxt_s = wr_ptr_r;
    commit_nxt_s = commit_ptr_r;
    we_s         = 1'b0;
    inc_ok_s     = 1'b0;
    inc_filt_s   = 1'b0;
    inc_err_s    = 1'b0;
    inc_ovf_s    = 1'b0;
    case (state_r)
      IDLE, STORE: begin
        if (s_axis_tvalid) begin
          if ((state_r == IDLE) && !addr_ok_s) begin
            inc_filt_s  = 1'b1;
            state_nxt_s = s_axis_tlast ? IDLE : DISCARD;
          end else if (full_s) begin
            // Drop the partial frame; the buffer only ever holds whole frames
            wr_ptr_nxt_s = commit_ptr_r;
            inc_ovf_s    = 1'b1;
            state_nxt_s  = s_axis_tlast ? IDLE : DISCARD;
          end else if (s_axis_tlast && s_axis_tuser) begin
            wr_ptr_nxt_s = commit_ptr_r;
            inc_err_s    = 1'b1;
            state_nxt_s  = IDLE;
          end else if (s_axis_tlast) begin
            we_s         = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            commit_nxt_s = wr_ptr_r + PTR_ONE;
            inc_ok_s     = 1'b1;
            state_nxt_s  = IDLE;
          end else begin
            we_s         = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            state_nxt_s  = STORE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) state_nxt_s = IDLE;
        else                               state_nxt_s = DISCARD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Writer state, pointers and statistics counters
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      wr_ptr_r      <= '0;
      commit_ptr_r  <= '0;
      frames_ok     <= 32'd0;
      drop_filter   <= 16'd0;
      drop_error    <= 16'd0;
      drop_overflow <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      commit_ptr_r <= commit_nxt_s;
      if (inc_ok_s)   frames_ok     <= frames_ok + 32'd1;
      if (inc_filt_s) drop_filter   <= sat_inc16(drop_filter);
      if (inc_err_s)  drop_error    <= sat_inc16(drop_error);
      if (inc_ovf_s)  drop_overflow <= sat_inc16(drop_overflow);
    end
  end

  // Buffer write port
  always_ff @(posedge clock) begin
    if (we_s) mem[wr_ptr_r[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Reads are issued only while words are committed and the output stage,
  // counting the read in flight, still has a free slot after this cycle's pop
  assign pop_s   = v0_r && m_axis_tready;
  assign occ_s   = {2'b00, v0_r} + {2'b00, v1_r} + {2'b00, pend_r} - {2'b00, pop_s};
  assign issue_s = (rd_ptr_r != commit_ptr_r) && (occ_s < 3'd2);

  // Buffer read port (one-cycle latency)
  always_ff @(posedge clock) begin
    if (issue_s) rd_word_r <= mem[rd_ptr_r[AW-1:0]];
  end

  // Read pointer and read-in-flight flag
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      pend_r   <= 1'b0;
    end else begin
      if (issue_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      pend_r <= issue_s;
    end
  end

  // Two-entry output stage: shift on pop, then land the returning read word
  always_comb begin
    q0_nxt_s = q0_r;
    q1_nxt_s = q1_r;
    v0_nxt_s = v0_r;
    v1_nxt_s = v1_r;
    if (pop_s) begin
      q0_nxt_s = q1_r;
      v0_nxt_s = v1_r;
      v1_nxt_s = 1'b0;
    end else begin
      v1_nxt_s = v1_r;
    end
    if (pend_r) begin
      if (!v0_nxt_s) begin
        q0_nxt_s = rd_word_r;
        v0_nxt_s = 1'b1;
      end else begin
        q1_nxt_s = rd_word_r;
        v1_nxt_s = 1'b1;
      end
    end else begin
      q1_nxt_s = q1_nxt_s;
    end
  end

  // Output stage registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q0_r <= '0;
      q1_r <= '0;
      v0_r <= 1'b0;
      v1_r <= 1'b0;
    end else begin
      q0_r <= q0_nxt_s;
      q1_r <= q1_nxt_s;
      v0_r <= v0_nxt_s;
      v1_r <= v1_nxt_s;
    end
  end

  assign m_axis_tvalid = v0_r;
  assign m_axis_tlast  = q0_r[72];
  assign m_axis_tkeep  = q0_r[71:64];
  assign m_axis_tdata  = q0_r[63:0];

endmodule

// File: doc/eth_rx_frame_filter.md
# eth_rx_frame_filter

Store-and-forward receive filter between the 10G MAC receive AXI-Stream (64-bit, `gt_clock` domain) and the receive side of the `ethernet` DMA engine. Every incoming frame is buffered whole. A frame is released downstream only if all three conditions hold:
- its destination MAC passes the address filter;
- the MAC did not flag it bad (`tuser`);
- it fit in the buffer.

Rejected frames are discarded atomically and counted, so the DMA never sees a partial or errored frame.

## Interface
Parameters:
- `depth_log2`, default 9: buffer depth of 2^depth_log2 64-bit words (512 words = 4 KiB).

Ports:
- `clock`, in, 1: single clock; all logic is rising-edge. Connected to `gt_clock`.
- `async_resetn`, in, 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronized internally to `clock`.
- `mac_addr`, in, 48: station address. Bits [47:40] are the first byte on the wire.
- `promiscuous`, in, 1: when 1, the address filter accepts every frame.
- `s_axis_tdata`, in, 64: MAC receive data. Byte 0 is bits [7:0].
- `s_axis_tkeep`, in, 8: byte enables.
- `s_axis_tlast`, in, 1: last beat of the frame.
- `s_axis_tuser`, in, 1: bad-frame flag, meaningful only on the `tlast` beat.
- `s_axis_tvalid`, in, 1: beat valid.
- `s_axis_tready`, out, 1: 0 in reset, 1 otherwise. The block never backpressures the MAC.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tlast`, out, 64 / 8 / 1: frame data to the DMA engine.
- `m_axis_tvalid`, out, 1; `m_axis_tready`, in, 1: standard AXI-Stream handshake on the output.
- `frames_ok`, out, 32: count of frames committed to the buffer.
- `drop_filter`, out, 16: frames rejected by the address filter.
- `drop_error`, out, 16: frames dropped because `tuser` was 1 on the last beat.
- `drop_overflow`, out, 16: frames dropped because the buffer filled.

## Operation
- **Buffer contents:** each buffer word is {tlast, tkeep, tdata}, 73 bits. Storage is simple dual-port RAM with a 1-cycle read.
- **Pointers:** three pointers, each depth_log2+1 bits wide: `wr_ptr`, `commit_ptr`, `rd_ptr`.
  - Full: `wr_ptr - rd_ptr == 2^depth_log2`.
  - Frame available: `rd_ptr != commit_ptr`.
- **Writer FSM, IDLE:** waits for the first beat of a frame.
  - Destination MAC = bytes 0..5, i.e. tdata[7:0] is compared against mac_addr[47:40].
  - Accept if `promiscuous`, or dst == FF:FF:FF:FF:FF:FF, or dst == `mac_addr`. `mac_addr` and `promiscuous` are sampled on this beat only.
  - Accepted: write the beat, go to STORE.
  - Rejected: increment `drop_filter`; go to DISCARD unless this beat has tlast.
- **Writer FSM, STORE:** write each valid beat.
- **Writer FSM, DISCARD:** ignore beats until a beat with tlast, then go to IDLE.
- **End of an accepted frame (tlast beat):**
  - tuser=0: write the beat, set `commit_ptr` to the new `wr_ptr`, increment `frames_ok`, go to IDLE.
  - tuser=1: set `wr_ptr` back to `commit_ptr`, increment `drop_error`, go to IDLE.
- **Overflow:** a valid beat arriving in IDLE or STORE while the buffer is full is not written.
  - `wr_ptr` rewinds to `commit_ptr` and `drop_overflow` increments.
  - The FSM goes to DISCARD, or to IDLE if that beat carried tlast.
  - Any frame longer than 2^depth_log2 beats is always dropped this way.
- **Single-beat frame:** filter, tuser and commit decisions are all made in the same cycle.
- **Gaps:** beats with `tvalid`=0 mid-frame are allowed and do not change state.
- **Reader:** prefetches from RAM into a 2-entry output stage so that `m_axis_tvalid` never depends combinationally on `m_axis_tready`. The reader only ever reads committed words.
- **Counters:**
  - `frames_ok` wraps modulo 2^32.
  - The drop counters saturate at 0xFFFF.
  - Each counter increments at most once per cycle.
- **Reset (any time):** pointers go to 0, FSM to IDLE, counters to 0. All outputs go to 0: `m_axis_*`, `s_axis_tready` and the counters. Frames in progress and buffered frames are lost.

## Timing
- Commit latency: the tlast beat accepted in cycle N makes the first beat of that frame visible on `m_axis_tvalid` no later than cycle N+3.
- Throughput: with `m_axis_tready` held at 1, output runs at 1 beat/cycle, with back-to-back frames and no bubbles.
- Buffer space freed by a read is usable by the writer in the following cycle.
- Simultaneous write-commit and read in the same cycle are legal. Reading the last committed word while a commit occurs does not stall the output.
- `m_axis_*` are held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.

## Test plan
- **Matching unicast:** `mac_addr`=02:00:00:00:00:01, one 64-byte frame (8 beats, last tkeep=FF), tuser=0.
  - Same 8 beats out in order.
  - `frames_ok`=1.
  - First output beat no later than 3 cycles after the tlast beat.
- **Filter:** frames to 02:00:00:00:00:02 and to FF:FF:FF:FF:FF:FF, `promiscuous`=0.
  - Only the broadcast frame is output; `drop_filter`=1.
  - Repeat with `promiscuous`=1: both frames are output.
- **Error:** 3-beat frame with tuser=1 on tlast, followed by a good 2-beat frame.
  - Only the 2-beat frame is output; `drop_error`=1.
  - `wr_ptr` equals `commit_ptr` after the drop.
- **Overflow:** `depth_log2`=4, `m_axis_tready`=0, a 20-beat frame followed by a 4-beat frame.
  - `drop_overflow`=1; the 4-beat frame is stored and output after `m_axis_tready`=1.
- **Backpressure and gaps:** random tvalid gaps on input, random `m_axis_tready` on output, 200 random frames of 1–190 beats.
  - Output is byte-identical to accepted input and no beat changes while stalled.
- **Reset mid-frame:** assert `async_resetn`=0 during beat 3 of a 6-beat frame.
  - All outputs are 0 immediately; after release the next good frame passes and `frames_ok`=1.
